// File: rtl/sample_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sample_tx_scheduler_pkg
// Shared definitions for the sample transmit scheduler: byte width, the frame
// FSM state encoding and a ceiling-log2 helper used to size the channel index,
// the round-robin pointer and the byte counter.
// -----------------------------------------------------------------------------
package sample_tx_scheduler_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so that single-entry ranges still get a
  // usable one-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sample_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Picks the first requesting channel
// starting at ptr and wrapping at NUM_CH.
//   req  : per-channel request
//   ptr  : channel with highest priority this cycle
//   gnt  : one-hot grant (all-zero when nothing requests)
//   idx  : binary index of the granted channel (0 when nothing requests)
//   any  : at least one channel is requesting
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  int              c_int;
  logic [IDX_W-1:0] c_idx;

  // Walk offsets from the farthest to the nearest; the last hit written is
  // the nearest requester to ptr, so no priority flag is needed.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    c_int = 0;
    c_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c_int = (int'(ptr) + k) % NUM_CH;
      c_idx = IDX_W'(c_int);
      if (req[c_idx]) begin
        gnt        = '0;
        gnt[c_idx] = 1'b1;
        idx        = c_idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_tx_scheduler.sv
// -----------------------------------------------------------------------------
// sample_tx_scheduler
// Shares one byte-wide transmit link among NUM_CH sample sources. Grants
// sources round-robin, captures the granted word into a shadow register and
// sends an optional channel-tagged header followed by the word, MSB first,
// over a valid/ready handshake.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   ch_valid    : per-channel sample available
//   ch_data     : channel i occupies bits [i*W +: W], W = WORD_BYTES*8
//   ch_ready    : one-hot grant, only while idle
//   tx_valid    : tx_byte is valid (registered)
//   tx_byte     : byte to transmit (registered)
//   tx_ready    : transmitter accepts tx_byte this cycle
//   busy        : a frame is in progress
//   frame_done  : one-cycle pulse after the last byte of a frame is accepted
// -----------------------------------------------------------------------------
module sample_tx_scheduler
  import sample_tx_scheduler_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          WORD_BYTES  = 4,
  parameter int          HEADER_EN   = 1,
  parameter logic [7:0]  HEADER_BASE = 8'hA0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_valid,
  input  logic [NUM_CH*WORD_BYTES*8-1:0]   ch_data,
  output logic [NUM_CH-1:0]                ch_ready,
  output logic                             tx_valid,
  output logic [7:0]                       tx_byte,
  input  logic                             tx_ready,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int WORD_W = WORD_BYTES * BYTE_W;
  localparam int IDX_W  = clog2(NUM_CH);
  localparam int CNT_W  = clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

  // Byte of a word counted from the MSB end: n=0 is the most significant.
  function automatic logic [BYTE_W-1:0] msb_byte(input logic [WORD_W-1:0] w,
                                                  input logic [CNT_W-1:0]  n);
    return w[(WORD_BYTES - 1 - int'(n)) * BYTE_W +: BYTE_W];
  endfunction

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                frame_done_q, frame_done_d;

  logic [NUM_CH-1:0]   arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [WORD_W-1:0]   gnt_word;
  logic                hs;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req (ch_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign gnt_word   = ch_data[int'(arb_idx) * WORD_W +: WORD_W];
  assign hs         = tx_valid_q & tx_ready;

  // Grant is only offered while idle, and never while reset is held.
  assign ch_ready   = (!rst && state_q == IDLE) ? arb_gnt : '0;
  assign tx_valid   = tx_valid_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      byte_cnt_q   <= '0;
      shadow_q     <= '0;
      idx_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      shadow_q     <= shadow_d;
      idx_q        <= idx_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    shadow_d     = shadow_q;
    idx_d        = idx_q;
    tx_valid_d   = tx_valid_q;
    tx_byte_d    = tx_byte_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          shadow_d   = gnt_word;
          idx_d      = arb_idx;
          rr_ptr_d   = (int'(arb_idx) == NUM_CH - 1) ? '0 : arb_idx + 1'b1;
          tx_valid_d = 1'b1;
          byte_cnt_d = '0;
          if (HEADER_EN != 0) begin
            state_d   = HEADER;
            tx_byte_d = HEADER_BASE | BYTE_W'(arb_idx);
          end else begin
            // No header: the first byte comes straight from the live input
            // because the shadow register is only being loaded this edge.
            state_d   = DATA;
            tx_byte_d = msb_byte(gnt_word, '0);
          end
        end
      end

      HEADER: begin
        if (hs) begin
          state_d    = DATA;
          byte_cnt_d = '0;
          tx_byte_d  = msb_byte(shadow_q, '0);
        end
      end

      DATA: begin
        if (hs) begin
          if (byte_cnt_q == LAST_CNT) begin
            state_d      = IDLE;
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            tx_byte_d  = msb_byte(shadow_q, byte_cnt_q + 1'b1);
          end
        end
      end

      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sample_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sample_tx_scheduler
// Two scheduler instances (with and without header) share one stimulus. A
// frame-level model per instance (pending byte list, round-robin pointer)
// predicts every output each cycle; directed sequences pin literal values.
// -----------------------------------------------------------------------------
module tb_sample_tx_scheduler;

  localparam int N  = 4;
  localparam int WB = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     ch_valid = '0;
  logic [N*32-1:0]  ch_data = '0;
  logic             tx_ready = 1'b0;

  logic [N-1:0]     rdy [2];
  logic             tv  [2];
  logic [7:0]       tbyte [2];
  logic             bsy [2];
  logic             fd  [2];

  sample_tx_scheduler #(
    .NUM_CH(N), .WORD_BYTES(WB), .HEADER_EN(1), .HEADER_BASE(8'hA0)
  ) dut_hdr (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(rdy[0]), .tx_valid(tv[0]), .tx_byte(tbyte[0]),
    .tx_ready(tx_ready), .busy(bsy[0]), .frame_done(fd[0])
  );

  sample_tx_scheduler #(
    .NUM_CH(N), .WORD_BYTES(WB), .HEADER_EN(0), .HEADER_BASE(8'hA0)
  ) dut_raw (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(rdy[1]), .tx_valid(tv[1]), .tx_byte(tbyte[1]),
    .tx_ready(tx_ready), .busy(bsy[1]), .frame_done(fd[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state per instance: bytes of the current frame and read position.
  logic [7:0] mbuf [2][8];
  int         mlen [2];
  int         mpos [2];
  int         mptr [2];
  logic       mdone [2];
  int         hen [2];

  initial begin
    hen[0] = 1; hen[1] = 0;
    for (int u = 0; u < 2; u++) begin
      mlen[u] = 0; mpos[u] = 0; mptr[u] = 0; mdone[u] = 1'b0;
    end
  end

  function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v, input int p);
    logic [N-1:0] g;
    g = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[(p + k) % N]) begin
        g = '0;
        g[(p + k) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    logic         pend;
    logic [31:0]  w;
    int           g;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        chk($sformatf("rst_ch_ready[%0d]", u), 32'(rdy[u]), 32'h0);
        chk($sformatf("rst_tx_valid[%0d]", u), 32'(tv[u]), 32'h0);
        chk($sformatf("rst_tx_byte[%0d]", u), 32'(tbyte[u]), 32'h0);
        chk($sformatf("rst_busy[%0d]", u), 32'(bsy[u]), 32'h0);
        chk($sformatf("rst_frame_done[%0d]", u), 32'(fd[u]), 32'h0);
        mlen[u] = 0; mpos[u] = 0; mptr[u] = 0; mdone[u] = 1'b0;
      end else begin
        pend = (mpos[u] < mlen[u]);
        eg   = pend ? '0 : exp_grant(ch_valid, mptr[u]);
        chk($sformatf("ch_ready[%0d]", u), 32'(rdy[u]), 32'(eg));
        chk($sformatf("tx_valid[%0d]", u), 32'(tv[u]), 32'(pend));
        if (pend)
          chk($sformatf("tx_byte[%0d]", u), 32'(tbyte[u]), 32'(mbuf[u][mpos[u]]));
        chk($sformatf("busy[%0d]", u), 32'(bsy[u]), 32'(pend));
        chk($sformatf("frame_done[%0d]", u), 32'(fd[u]), 32'(mdone[u]));
        mdone[u] = 1'b0;
        if (pend) begin
          if (tx_ready) begin
            mpos[u]++;
            if (mpos[u] == mlen[u]) mdone[u] = 1'b1;
          end
        end else if (eg != '0) begin
          g = 0;
          for (int k = 0; k < N; k++) if (eg[k]) g = k;
          w = ch_data[g*32 +: 32];
          mlen[u] = 0; mpos[u] = 0;
          if (hen[u] != 0) begin
            mbuf[u][0] = 8'hA0 | 8'(g);
            mlen[u] = 1;
          end
          for (int b = WB - 1; b >= 0; b--) begin
            mbuf[u][mlen[u]] = w[b*8 +: 8];
            mlen[u]++;
          end
          mptr[u] = (g + 1) % N;
        end
      end
    end
  end

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    edge_drive();
    rst = 1'b1; ch_valid = '0;
    edge_drive();
    rst = 1'b0;
  endtask

  logic [7:0] e1 [5];
  logic [7:0] e4 [4];

  initial begin
    e1[0] = 8'hA2; e1[1] = 8'hDE; e1[2] = 8'hAD; e1[3] = 8'hBE; e1[4] = 8'hEF;
    e4[0] = 8'h01; e4[1] = 8'h02; e4[2] = 8'h03; e4[3] = 8'h04;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single channel 2 frame, then rr_ptr must point at channel 3.
    ch_data[2*32 +: 32] = 32'hDEADBEEF;
    ch_valid = 4'b0100;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t1_grant", 32'(rdy[0]), 32'h4);
    edge_drive();
    ch_valid = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t1_valid%0d", i), 32'(tv[0]), 32'h1);
      chk($sformatf("t1_byte%0d", i), 32'(tbyte[0]), 32'(e1[i]));
    end
    edge_drive();
    for (int k = 0; k < N; k++) ch_data[k*32 +: 32] = 32'h11111111 * (k + 1);
    ch_valid = '1;
    @(negedge clk);
    chk("t1_frame_done", 32'(fd[0]), 32'h1);
    chk("t1_next_grant_ch3", 32'(rdy[0]), 32'h8);

    // All channels valid: headers rotate A3,A0,A1,A2 every 6 cycles.
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      chk($sformatf("t2_header%0d", f), 32'(tbyte[0]), 32'(8'hA0 | 8'((3 + f) % 4)));
      repeat (5) @(negedge clk);
    end

    // Stalls with a 1,0,0 ready pattern, then fully random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      edge_drive();
      if (cyc < 300) tx_ready = (cyc % 3 == 0);
      else           tx_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) ch_valid = N'($urandom);
      if ($urandom_range(0, 5) == 0)
        ch_data[$urandom_range(0, N-1)*32 +: 32] = $urandom;
      rst = (cyc > 300) && ($urandom_range(0, 499) == 0);
    end

    // No-header instance: word 01020304 on channel 0.
    do_reset();
    ch_data[31:0] = 32'h01020304;
    ch_valid = 4'b0001;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t4_grant", 32'(rdy[1]), 32'h1);
    edge_drive();
    ch_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4_byte%0d", i), 32'(tbyte[1]), 32'(e4[i]));
    end
    @(negedge clk);
    chk("t4_frame_done", 32'(fd[1]), 32'h1);

    // Reset after the second data byte is accepted.
    do_reset();
    ch_data[1*32 +: 32] = 32'h55667788;
    ch_valid = 4'b0010;
    edge_drive();
    ch_valid = '0;
    repeat (3) @(negedge clk);
    chk("t5_second_data", 32'(tbyte[0]), 32'h66);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_drop", 32'(tv[0]), 32'h0);
    edge_drive();
    rst = 1'b0;
    ch_valid = 4'b1001;
    @(negedge clk);
    chk("t5_grant_ch0", 32'(rdy[0]), 32'h1);
    edge_drive();
    ch_valid = '0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
